mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: NUM_TAGS, default `NUM_MEM_TAGS (15), number of memory tags (tag 0 = no grant/no response); STARVE_LIMIT, default 4, consecutive icache-losing cycles before icache is forced to win.
REQ-002 clock  in  1  system clock; the only clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ic_req_valid_i  in  1  icache refill request; ic_req_addr_i  in  ADDR  block address.
REQ-005 ic_req_gnt_o  out  1  icache request accepted this cycle; ic_req_tag_o  out  MEM_TAG  tag assigned (valid with grant).
REQ-006 dc_req_valid_i  in  1; dc_req_cmd_i  in  MEM_COMMAND  (MEM_LOAD/MEM_STORE); dc_req_addr_i  in  ADDR; dc_req_data_i  in  MEM_BLOCK  store data.
REQ-007 dc_req_gnt_o  out  1; dc_req_tag_o  out  MEM_TAG  dcache grant/tag.
REQ-008 mem_command_o  out  MEM_COMMAND; mem_addr_o  out  ADDR; mem_data_o  out  MEM_BLOCK: single memory request port.
REQ-009 mem_tag_i  in  MEM_TAG  memory acceptance tag (0 = rejected); mem_data_tag_i  in  MEM_TAG; mem_data_i  in  MEM_BLOCK  returning response.
REQ-010 ic_resp_valid_o  out  1; ic_resp_tag_o  out  MEM_TAG; ic_resp_data_o  out  MEM_BLOCK: routed icache response.
REQ-011 dc_resp_valid_o  out  1; dc_resp_tag_o  out  MEM_TAG; dc_resp_data_o  out  MEM_BLOCK: routed dcache load response.
REQ-012 flush_ic_i  in  1  fetch redirect; squash all outstanding icache refills.

Function
REQ-013 Winner selection combinational: dcache wins when both valid, unless starve_cnt == STARVE_LIMIT, then icache wins; sole valid requester wins; none -> mem_command_o = MEM_NONE, addr/data '0.
REQ-014 Memory port driven from winner same cycle; icache requests issue MEM_LOAD, mem_data_o '0.
REQ-015 Grant = winner issued && mem_tag_i != 0 && !(winner is icache && flush_ic_i); *_tag_o = mem_tag_i; loser gnt = 0.
REQ-016 flush_ic_i cycle: icache never drives memory; mem_command_o reflects dcache request or MEM_NONE.
REQ-017 Owner table, NUM_TAGS+1 entries indexed by tag, each {valid, owner IC/DC, squashed}; entry 0 never valid.
REQ-018 On granted load (icache or dcache): entry[mem_tag_i] <= {1, owner, 0}; granted stores allocate nothing and never produce a response.
REQ-019 On mem_data_tag_i != 0 with entry valid: clear entry; route data to owner's resp port, resp_valid = 1, tag echoed, same cycle (0 latency); squashed IC entry -> cleared, no resp_valid.
REQ-020 mem_data_tag_i == 0 or entry invalid: response dropped, both resp_valid = 0, table unchanged.
REQ-021 Same-cycle response and allocation on same tag: response processed from old entry, allocation written (allocation wins).
REQ-022 flush_ic_i: all valid IC entries squashed next cycle; an IC response arriving in the flush cycle is suppressed (resp_valid = 0) and its entry cleared.
REQ-023 starve_cnt (width clog2(STARVE_LIMIT+1)): +1 when ic_req_valid_i && !ic_req_gnt_o && dc_req_gnt_o, saturating at STARVE_LIMIT; reset to 0 on ic_req_gnt_o or !ic_req_valid_i; hold otherwise.
REQ-024 Response data output '0 when respective resp_valid = 0.

Reset
REQ-025 On reset: all owner entries invalid, starve_cnt = 0; outputs combinational from inputs with empty table (resp_valid = 0).
REQ-026 Reset mid-operation discards all outstanding tags; later responses for them dropped per REQ-020.

Structure
REQ-027 MEM_COMMAND, MEM_TAG, MEM_BLOCK, ADDR, `NUM_MEM_TAGS from sys_defs.svh; new typedef MEM_OWNER {OWNER_IC, OWNER_DC} and MEM_OWNER_ENTRY added there.
REQ-028 One sub-module natural: mem_owner_table (allocate/lookup-clear/squash-all ports); arbitration and starvation counter in top.

Verification
REQ-029 Only icache valid, addr 0x100, mem_tag_i = 3 -> ic_req_gnt_o = 1, tag 3; later mem_data_tag_i = 3 -> ic_resp_valid_o = 1, data routed, entry 3 cleared.
REQ-030 Both valid 5 cycles, mem_tag_i nonzero, STARVE_LIMIT = 4 -> dcache granted cycles 0-3, icache granted cycle 4, starve_cnt back to 0.
REQ-031 dc store granted tag 5, then mem_data_tag_i = 5 -> no resp_valid on either port.
REQ-032 IC tags 2,7 outstanding, flush_ic_i pulse, responses tags 2,7 -> ic_resp_valid_o stays 0; concurrent dc load tag 9 response delivered.
REQ-033 Response tag 4 (IC) and new dc grant tag 4 same cycle -> ic_resp_valid_o = 1; next response tag 4 -> dc_resp_valid_o = 1.
REQ-034 mem_tag_i = 0 with requests pending -> no grants, starve_cnt unchanged, table unchanged; reset with tags outstanding -> subsequent responses dropped.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory-interface types for the icache/dcache arbiter
package mem_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 15;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
    logic     squashed;
  } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_owner_table.sv
// rtl/mem_owner_table.sv - per-tag owner tracking for outstanding memory loads
module mem_owner_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           alloc_en_i,
  input  MEM_TAG         alloc_tag_i,
  input  MEM_OWNER       alloc_owner_i,
  input  MEM_TAG         lookup_tag_i,
  output MEM_OWNER_ENTRY lookup_entry_o,
  input  logic           clear_en_i,
  input  logic           squash_ic_i
);

  MEM_OWNER_ENTRY entries_q [NUM_TAGS+1];
  MEM_OWNER_ENTRY entries_d [NUM_TAGS+1];

  always_comb begin
    lookup_entry_o = '0;
    if (lookup_tag_i != '0 && int'(lookup_tag_i) <= NUM_TAGS)
      lookup_entry_o = entries_q[lookup_tag_i];
  end

  // Squash, then clear, then allocate: a same-tag allocation overrides the response clear.
  always_comb begin
    for (int i = 0; i <= NUM_TAGS; i++) begin
      entries_d[i] = entries_q[i];
      if (squash_ic_i && entries_q[i].valid && entries_q[i].owner == OWNER_IC)
        entries_d[i].squashed = 1'b1;
      if (clear_en_i && int'(lookup_tag_i) == i)
        entries_d[i] = '0;
      if (alloc_en_i && int'(alloc_tag_i) == i)
        entries_d[i] = '{valid: 1'b1, owner: alloc_owner_i, squashed: 1'b0};
    end
    entries_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= NUM_TAGS; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i <= NUM_TAGS; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbitration onto one memory port with tagged response routing
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ic_req_valid_i,
  input  ADDR        ic_req_addr_i,
  output logic       ic_req_gnt_o,
  output MEM_TAG     ic_req_tag_o,
  input  logic       dc_req_valid_i,
  input  MEM_COMMAND dc_req_cmd_i,
  input  ADDR        dc_req_addr_i,
  input  MEM_BLOCK   dc_req_data_i,
  output logic       dc_req_gnt_o,
  output MEM_TAG     dc_req_tag_o,
  output MEM_COMMAND mem_command_o,
  output ADDR        mem_addr_o,
  output MEM_BLOCK   mem_data_o,
  input  MEM_TAG     mem_tag_i,
  input  MEM_TAG     mem_data_tag_i,
  input  MEM_BLOCK   mem_data_i,
  output logic       ic_resp_valid_o,
  output MEM_TAG     ic_resp_tag_o,
  output MEM_BLOCK   ic_resp_data_o,
  output logic       dc_resp_valid_o,
  output MEM_TAG     dc_resp_tag_o,
  output MEM_BLOCK   dc_resp_data_o,
  input  logic       flush_ic_i
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]  starve_q, starve_d;
  logic           ic_wins, dc_wins, lookup_hit, alloc_en;
  MEM_OWNER       alloc_owner;
  MEM_OWNER_ENTRY lookup_entry;

  always_comb begin
    ic_wins       = ic_req_valid_i && !flush_ic_i && (!dc_req_valid_i || starve_q == LIMIT);
    dc_wins       = dc_req_valid_i && !ic_wins;
    mem_command_o = MEM_NONE;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    if (ic_wins) begin
      mem_command_o = MEM_LOAD;
      mem_addr_o    = ic_req_addr_i;
    end else if (dc_wins) begin
      mem_command_o = dc_req_cmd_i;
      mem_addr_o    = dc_req_addr_i;
      mem_data_o    = dc_req_data_i;
    end
    ic_req_gnt_o = ic_wins && mem_tag_i != '0;
    dc_req_gnt_o = dc_wins && mem_tag_i != '0 && dc_req_cmd_i != MEM_NONE;
    ic_req_tag_o = mem_tag_i;
    dc_req_tag_o = mem_tag_i;
    alloc_en     = ic_req_gnt_o || (dc_req_gnt_o && dc_req_cmd_i == MEM_LOAD);
    alloc_owner  = ic_req_gnt_o ? OWNER_IC : OWNER_DC;
  end

  // Responses are suppressed while reset is held so outputs look like an empty table.
  always_comb begin
    lookup_hit      = !reset && mem_data_tag_i != '0 && lookup_entry.valid;
    ic_resp_valid_o = lookup_hit && lookup_entry.owner == OWNER_IC
                      && !lookup_entry.squashed && !flush_ic_i;
    dc_resp_valid_o = lookup_hit && lookup_entry.owner == OWNER_DC;
    ic_resp_tag_o   = ic_resp_valid_o ? mem_data_tag_i : '0;
    ic_resp_data_o  = ic_resp_valid_o ? mem_data_i : '0;
    dc_resp_tag_o   = dc_resp_valid_o ? mem_data_tag_i : '0;
    dc_resp_data_o  = dc_resp_valid_o ? mem_data_i : '0;
  end

  always_comb begin
    starve_d = starve_q;
    if (!ic_req_valid_i || ic_req_gnt_o)
      starve_d = '0;
    else if (dc_req_gnt_o && starve_q != LIMIT)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  mem_owner_table #(.NUM_TAGS(NUM_TAGS)) u_owner_table (
    .clock          (clock),
    .reset          (reset),
    .alloc_en_i     (alloc_en),
    .alloc_tag_i    (mem_tag_i),
    .alloc_owner_i  (alloc_owner),
    .lookup_tag_i   (mem_data_tag_i),
    .lookup_entry_o (lookup_entry),
    .clear_en_i     (lookup_hit),
    .squash_ic_i    (flush_ic_i)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a tag-table model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       ic_v, dc_v, flush;
  ADDR        ic_addr, dc_addr;
  MEM_COMMAND dc_cmd;
  MEM_BLOCK   dc_data, rdata;
  MEM_TAG     mtag, dtag;

  logic       ic_req_gnt_o, dc_req_gnt_o, ic_resp_valid_o, dc_resp_valid_o;
  MEM_TAG     ic_req_tag_o, dc_req_tag_o, ic_resp_tag_o, dc_resp_tag_o;
  MEM_COMMAND mem_command_o;
  ADDR        mem_addr_o;
  MEM_BLOCK   mem_data_o, ic_resp_data_o, dc_resp_data_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: who owns each tag, whether squashed, and the icache losing streak.
  bit m_valid [16];
  bit m_is_dc [16];
  bit m_sq    [16];
  int m_starve;

  logic o_icg, o_dcg, o_icr, o_dcr;

  mem_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(STARVE)) dut (
    .clock(clock), .reset(reset),
    .ic_req_valid_i(ic_v), .ic_req_addr_i(ic_addr),
    .ic_req_gnt_o(ic_req_gnt_o), .ic_req_tag_o(ic_req_tag_o),
    .dc_req_valid_i(dc_v), .dc_req_cmd_i(dc_cmd), .dc_req_addr_i(dc_addr),
    .dc_req_data_i(dc_data), .dc_req_gnt_o(dc_req_gnt_o), .dc_req_tag_o(dc_req_tag_o),
    .mem_command_o(mem_command_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_tag_i(mtag), .mem_data_tag_i(dtag), .mem_data_i(rdata),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_tag_o(ic_resp_tag_o),
    .ic_resp_data_o(ic_resp_data_o), .dc_resp_valid_o(dc_resp_valid_o),
    .dc_resp_tag_o(dc_resp_tag_o), .dc_resp_data_o(dc_resp_data_o),
    .flush_ic_i(flush)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ic_v = 0; dc_v = 0; flush = 0; reset = 0;
    ic_addr = '0; dc_addr = '0; dc_cmd = MEM_LOAD; dc_data = '0;
    mtag = '0; dtag = '0; rdata = '0;
  endtask

  task automatic cycle();
    int         win;
    bit         e_icg, e_dcg, hit, e_icr, e_dcr;
    MEM_COMMAND e_cmd;
    ADDR        e_addr;
    MEM_BLOCK   e_data;
    #3;
    if (ic_v && !flush && (!dc_v || m_starve == STARVE)) win = 1;
    else if (dc_v) win = 2;
    else win = 0;
    e_cmd  = (win == 1) ? MEM_LOAD : (win == 2) ? dc_cmd : MEM_NONE;
    e_addr = (win == 1) ? ic_addr : (win == 2) ? dc_addr : '0;
    e_data = (win == 2) ? dc_data : '0;
    e_icg  = (win == 1) && mtag != 0;
    e_dcg  = (win == 2) && mtag != 0;
    hit    = !reset && dtag != 0 && m_valid[dtag];
    e_icr  = hit && !m_is_dc[dtag] && !m_sq[dtag] && !flush;
    e_dcr  = hit && m_is_dc[dtag];

    chk("mem_command", mem_command_o, e_cmd);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_data", mem_data_o, e_data);
    chk("ic_gnt", ic_req_gnt_o, e_icg);
    chk("dc_gnt", dc_req_gnt_o, e_dcg);
    if (e_icg) chk("ic_tag", ic_req_tag_o, mtag);
    if (e_dcg) chk("dc_tag", dc_req_tag_o, mtag);
    chk("ic_resp_valid", ic_resp_valid_o, e_icr);
    chk("dc_resp_valid", dc_resp_valid_o, e_dcr);
    chk("ic_resp_data", ic_resp_data_o, e_icr ? rdata : '0);
    chk("dc_resp_data", dc_resp_data_o, e_dcr ? rdata : '0);
    if (e_icr) chk("ic_resp_tag", ic_resp_tag_o, dtag);
    if (e_dcr) chk("dc_resp_tag", dc_resp_tag_o, dtag);
    o_icg = ic_req_gnt_o; o_dcg = dc_req_gnt_o;
    o_icr = ic_resp_valid_o; o_dcr = dc_resp_valid_o;

    if (reset) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      m_starve = 0;
    end else begin
      if (flush)
        for (int i = 0; i < 16; i++) if (m_valid[i] && !m_is_dc[i]) m_sq[i] = 1;
      if (hit) m_valid[dtag] = 0;
      if (e_icg) begin
        m_valid[mtag] = 1; m_is_dc[mtag] = 0; m_sq[mtag] = 0;
      end
      if (e_dcg && dc_cmd == MEM_LOAD) begin
        m_valid[mtag] = 1; m_is_dc[mtag] = 1; m_sq[mtag] = 0;
      end
      if (!ic_v || e_icg) m_starve = 0;
      else if (e_dcg && m_starve < STARVE) m_starve++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_is_dc[i] = 0; m_sq[i] = 0; end
    m_starve = 0;
    idle();
    reset = 1;
    @(posedge clock); #1;
    cycle(); cycle();
    idle();

    // Lone icache refill and its response.
    ic_v = 1; ic_addr = 32'h100; mtag = 3;
    cycle(); chk("req029_gnt", o_icg, 1'b1);
    idle(); cycle();
    dtag = 3; rdata = 64'hdead_beef_0123_4567;
    cycle(); chk("req029_resp", o_icr, 1'b1);
    cycle(); chk("req029_cleared", o_icr, 1'b0);
    idle();

    // Starvation: dcache wins four times, then icache is forced through.
    for (int k = 0; k < 5; k++) begin
      ic_v = 1; dc_v = 1; dc_cmd = MEM_STORE; ic_addr = 32'h200 + k;
      dc_addr = 32'h300 + k; dc_data = 64'h55 + k; mtag = MEM_TAG'(10 + k);
      cycle();
      chk("req030_dc_gnt", o_dcg, k < 4);
      chk("req030_ic_gnt", o_icg, k == 4);
    end
    mtag = 15; cycle(); chk("req030_restart", o_dcg, 1'b1);
    idle();

    // Stores never produce a response.
    dc_v = 1; dc_cmd = MEM_STORE; dc_addr = 32'h400; dc_data = 64'h1234; mtag = 5;
    cycle(); chk("req031_gnt", o_dcg, 1'b1);
    idle(); dtag = 5; rdata = 64'h99;
    cycle(); chk("req031_no_ic", o_icr, 1'b0); chk("req031_no_dc", o_dcr, 1'b0);
    idle();

    // Flush squashes outstanding icache refills; dcache load survives.
    ic_v = 1; ic_addr = 32'h500; mtag = 2; cycle();
    mtag = 7; cycle();
    idle(); dc_v = 1; dc_cmd = MEM_LOAD; dc_addr = 32'h600; mtag = 9; cycle();
    idle(); flush = 1; cycle();
    idle(); dtag = 2; rdata = 64'ha; cycle(); chk("req032_t2", o_icr, 1'b0);
    dtag = 7; cycle(); chk("req032_t7", o_icr, 1'b0);
    dtag = 9; rdata = 64'hb; cycle(); chk("req032_t9", o_dcr, 1'b1);
    idle();

    // Icache response arriving in the flush cycle itself.
    ic_v = 1; mtag = 8; cycle();
    idle(); flush = 1; dtag = 8; rdata = 64'hc; cycle(); chk("flush_cycle_resp", o_icr, 1'b0);
    idle(); dtag = 8; cycle(); chk("flush_cycle_cleared", o_icr, 1'b0);
    idle();

    // Response and reallocation of the same tag in one cycle.
    ic_v = 1; mtag = 4; cycle();
    idle(); dtag = 4; rdata = 64'hd; dc_v = 1; dc_cmd = MEM_LOAD; mtag = 4;
    cycle(); chk("req033_ic_resp", o_icr, 1'b1); chk("req033_dc_gnt", o_dcg, 1'b1);
    idle(); dtag = 4; rdata = 64'he; cycle(); chk("req033_dc_resp", o_dcr, 1'b1);
    idle();

    // Rejected tag, then reset discarding an outstanding refill.
    ic_v = 1; mtag = 6; cycle();
    dc_v = 1; dc_cmd = MEM_LOAD; mtag = 0; cycle();
    chk("req034_no_icg", o_icg, 1'b0); chk("req034_no_dcg", o_dcg, 1'b0);
    idle(); reset = 1; cycle();
    idle(); dtag = 6; rdata = 64'hf; cycle(); chk("req034_dropped", o_icr, 1'b0);
    idle();

    for (int n = 0; n < 500; n++) begin
      ic_v    = ($urandom_range(0, 99) < 60);
      dc_v    = ($urandom_range(0, 99) < 60);
      dc_cmd  = $urandom_range(0, 1) ? MEM_LOAD : MEM_STORE;
      ic_addr = $urandom;
      dc_addr = $urandom;
      dc_data = {$urandom, $urandom};
      mtag    = ($urandom_range(0, 99) < 20) ? MEM_TAG'(0) : MEM_TAG'($urandom_range(1, 15));
      dtag    = MEM_TAG'($urandom_range(0, 15));
      rdata   = {$urandom, $urandom};
      flush   = ($urandom_range(0, 99) < 5);
      reset   = ($urandom_range(0, 99) < 1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
